audio_fir_filter: RTL and testbench

- Single-rate, time-multiplexed FIR filter for the audio path of the SDR receiver; sits after the demodulator and ahead of the audio output stage.
- Takes one signed 18-bit sample per handshake and uses one multiply-accumulate unit to iterate over all taps.
- Returns the full-precision signed 36-bit result with a one-cycle ready strobe.
- Uses the nd/rfd/rdy handshake so it can replace a vendor FIR core without changes to surrounding logic.

---
 rtl/audio_fir_filter.sv | 114 +++++++++++
 tb/tb_audio_fir_filter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_fir_filter.sv
// audio_fir_filter
//   Time-multiplexed single-rate FIR for the receiver audio path. One signed
//   sample is accepted per nd/rfd handshake, then a single multiply-accumulate
//   unit walks all NUM_TAPS taps, and the exact full-precision sum is
//   presented on dout with a one-cycle rdy strobe.
//
// Ports
//   clk  : system clock, rising edge
//   sclr : asynchronous active-high reset
//   nd   : new data, din valid this cycle
//   din  : signed input sample (DIN_W)
//   rfd  : ready for data; sample taken on an edge with nd=1 and rfd=1
//   rdy  : one-cycle strobe, dout holds a fresh result
//   dout : signed filter output (DOUT_W), held between rdy pulses
module audio_fir_filter #(
  parameter int DIN_W    = 18,
  parameter int COEF_W   = 14,
  parameter int NUM_TAPS = 16,
  parameter int DOUT_W   = 36,
  // h[0] sits in the least-significant COEF_W bits
  parameter logic [NUM_TAPS*COEF_W-1:0] COEFS = {
    14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd6, 14'd7, 14'd8,
    14'd8, 14'd7, 14'd6, 14'd5, 14'd4, 14'd3, 14'd2, 14'd1
  }
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     nd,
  input  logic signed [DIN_W-1:0]  din,
  output logic                     rfd,
  output logic                     rdy,
  output logic signed [DOUT_W-1:0] dout
);

  localparam int CNT_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = DIN_W + COEF_W;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic signed [DOUT_W-1:0] acc;
  logic signed [DIN_W-1:0]  x [NUM_TAPS];
  logic signed [COEF_W-1:0] coef [NUM_TAPS];

  // Constant coefficient ROM unpacked from the parameter vector.
  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_coef
      assign coef[gi] = COEFS[gi*COEF_W +: COEF_W];
    end
  endgenerate

  // Single shared multiplier: both operands signed, so the product is the
  // exact signed PROD_W-bit result; it is then sign-extended to the
  // accumulator width.
  logic signed [PROD_W-1:0] prod;
  logic signed [DOUT_W-1:0] prod_ext;

  assign prod     = x[cnt] * coef[cnt];
  assign prod_ext = {{(DOUT_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      dout  <= '0;
      rdy   <= 1'b0;
      rfd   <= 1'b1;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x[k] <= '0;
      end
    end else begin
      // rdy is only ever raised from OUT, so it is a single-cycle strobe.
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          rfd <= 1'b1;
          if (nd) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) begin
              x[k] <= x[k-1];
            end
            x[0]  <= din;
            acc   <= '0;
            cnt   <= '0;
            rfd   <= 1'b0;
            state <= MAC;
          end
        end
        MAC: begin
          // nd is ignored here: the delay line is frozen while taps are summed.
          rfd <= 1'b0;
          acc <= acc + prod_ext;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_TAP) begin
            state <= OUT;
          end
        end
        OUT: begin
          dout  <= acc;
          rdy   <= 1'b1;
          rfd   <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          rfd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fir_filter.sv
// Directed bench for audio_fir_filter: a vector table for impulse and
// negative full-scale responses, plus hand-written sequences for reset,
// handshake timing, ignored nd, mid-computation reset and a held-nd step.
module tb_audio_fir_filter;

  logic               clk;
  logic               sclr;
  logic               nd;
  logic signed [17:0] din;
  logic               rfd;
  logic               rdy;
  logic signed [35:0] dout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  audio_fir_filter dut (
    .clk  (clk),
    .sclr (sclr),
    .nd   (nd),
    .din  (din),
    .rfd  (rfd),
    .rdy  (rdy),
    .dout (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [17:0] din;
    logic signed [35:0] exp;
  } vec_t;

  vec_t vecs[34];

  task automatic chk(input string name, input logic signed [35:0] got,
                     input logic signed [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  // Wait (bounded) for rfd, present one sample for one edge.
  task automatic start(input logic signed [17:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!rfd && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rfd) begin
      checks++;
      errors++;
      $display("FAIL rfd_timeout: rfd stayed 0 for %0d cycles", n);
    end
    nd  = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    nd  = 1'b0;
  endtask

  // Wait (bounded) for the next rdy strobe and return dout.
  task automatic wait_rdy(output logic signed [35:0] y, output int at_cyc);
    int n;
    n = 0;
    y = 'x;
    at_cyc = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rdy) begin
        y = dout;
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: no rdy within %0d cycles", n);
    end
  endtask

  task automatic count_rdy(input int ncyc, output int hits);
    hits = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (rdy) hits++;
    end
  endtask

  initial begin
    int imp_exp[18] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    int ps[16]      = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 51, 57, 62, 66, 69, 71, 72};
    logic signed [35:0] y;
    int at, prev_at, hits, bad;

    for (int i = 0; i < 18; i++) begin
      vecs[i].din = (i == 0) ? 18'sd1 : 18'sd0;
      vecs[i].exp = 36'(imp_exp[i]);
    end
    for (int i = 0; i < 16; i++) begin
      vecs[18+i].din = -18'sd131072;
      vecs[18+i].exp = 36'(-131072 * ps[i]);
    end

    nd   = 1'b0;
    din  = '0;
    sclr = 1'b0;

    // Asynchronous reset between edges; outputs must react without a clock.
    #2 sclr = 1'b1;
    #1;
    chk("reset_dout", dout, 36'sd0);
    chk("reset_rdy", 36'(rdy), 36'sd0);
    chk("reset_rfd", 36'(rfd), 36'sd1);
    #99 sclr = 1'b0;
    count_rdy(50, hits);
    chk("idle_no_rdy", 36'(hits), 36'sd0);

    // Handshake timing with din=0 accepted at E0.
    @(negedge clk);
    nd  = 1'b1;
    din = '0;
    @(posedge clk);
    #1 nd = 1'b0;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (rfd !== 1'b0 || rdy !== 1'b0) bad++;
    end
    chk("busy_rfd_low_cycles_bad", 36'(bad), 36'sd0);
    @(negedge clk);
    chk("e17_rdy", 36'(rdy), 36'sd1);
    chk("e17_rfd", 36'(rfd), 36'sd1);
    chk("e17_dout", dout, 36'sd0);
    @(negedge clk);
    chk("e18_rdy_drop", 36'(rdy), 36'sd0);

    // Table: impulse response, then negative full-scale fill.
    for (int i = 0; i < 34; i++) begin
      start(vecs[i].din);
      wait_rdy(y, at);
      chk($sformatf("vec%0d_din%0d", i, vecs[i].din), y, vecs[i].exp);
    end

    // nd during MAC is dropped: history stays 16 x -131072 plus the new zero.
    start(18'sd0);
    repeat (5) @(negedge clk);
    nd  = 1'b1;
    din = 18'sd5000;
    @(negedge clk);
    nd  = 1'b0;
    wait_rdy(y, at);
    chk("ignored_nd_first", y, 36'(-131072 * 71));
    start(18'sd0);
    wait_rdy(y, at);
    chk("ignored_nd_second", y, 36'(-131072 * 69));

    // Reset during MAC aborts the result and clears the history.
    start(18'sd7);
    repeat (4) @(negedge clk);
    #2 sclr = 1'b1;
    #1;
    chk("midop_reset_dout", dout, 36'sd0);
    chk("midop_reset_rdy", 36'(rdy), 36'sd0);
    chk("midop_reset_rfd", 36'(rfd), 36'sd1);
    @(negedge clk);
    sclr = 1'b0;
    count_rdy(30, hits);
    chk("midop_no_rdy", 36'(hits), 36'sd0);
    for (int i = 0; i < 4; i++) begin
      start((i == 0) ? 18'sd1 : 18'sd0);
      wait_rdy(y, at);
      chk($sformatf("post_reset_impulse%0d", i), y, 36'(i + 1));
    end

    // Step with nd held high: 0 then 100 forever; rdy every 18 cycles.
    @(negedge clk);
    #2 sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    @(negedge clk);
    nd  = 1'b1;
    din = 18'sd0;
    @(posedge clk);
    @(negedge clk);
    din = 18'sd100;
    prev_at = -1;
    for (int k = 0; k < 19; k++) begin
      wait_rdy(y, at);
      chk($sformatf("step%0d", k), y,
          (k == 0) ? 36'sd0 : 36'(100 * ps[(k > 16) ? 15 : k - 1]));
      if (k > 0) chk($sformatf("step%0d_spacing", k), 36'(at - prev_at), 36'sd18);
      prev_at = at;
    end
    nd = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
